// File: rtl/fc_neuron_seq.sv
// rtl/fc_neuron_seq.sv - time-multiplexed fully-connected neuron, LANES MACs per beat
// Two-stage product/reduction pipeline feeding a wide accumulator, with optional ReLU.
module fc_neuron_seq #(
  parameter int WIDTH     = 8,
  parameter int W_WIDTH   = 8,
  parameter int IN        = 128,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = WIDTH + W_WIDTH + $clog2(IN) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              relu_en,
  input  logic signed [WIDTH+W_WIDTH-1:0]   bias,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic        [LANES*WIDTH-1:0]     x_data,
  input  logic        [LANES*W_WIDTH-1:0]   w_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [ACC_WIDTH-1:0]       z
);

  localparam int PW    = WIDTH + W_WIDTH;
  localparam int BEATS = IN / LANES;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  generate
    if (IN % LANES != 0) begin : g_bad_lanes
      $error("IN must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {ACCEPT, DRAIN, OUT} state_t;
  state_t state, state_nxt;

  logic [BCW-1:0]               beat_cnt;
  logic signed [PW-1:0]         prod_c [LANES];
  logic signed [PW-1:0]         p1_prod [LANES];
  logic                         p1_valid, p2_valid, acc_valid;
  logic signed [ACC_WIDTH-1:0]  lane_sum, p2_sum, acc, acc_bias;
  logic signed [PW-1:0]         bias_reg;
  logic                         relu_en_reg;
  logic                         in_fire, out_fire, last_beat, pipe_empty;

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign last_beat  = (beat_cnt == LAST_BEAT);
  // acc_valid delays the drain by one cycle so z is formed from a settled accumulator
  assign pipe_empty = !p1_valid && !p2_valid && !acc_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCEPT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT:  if (in_fire && last_beat) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty)           state_nxt = OUT;
      OUT:     if (out_fire)             state_nxt = ACCEPT;
      default:                           state_nxt = ACCEPT;
    endcase
  end

  always_comb begin
    in_ready = (state == ACCEPT);
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_c[k] = PW'($signed(x_data[k*WIDTH +: WIDTH])) *
                  PW'($signed(w_data[k*W_WIDTH +: W_WIDTH]));
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + ACC_WIDTH'(p1_prod[k]);
    end
  end

  assign acc_bias = acc + ACC_WIDTH'(bias_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      p1_valid    <= 1'b0;
      p2_valid    <= 1'b0;
      acc_valid   <= 1'b0;
      p2_sum      <= '0;
      acc         <= '0;
      bias_reg    <= '0;
      relu_en_reg <= 1'b0;
      out_valid   <= 1'b0;
      z           <= '0;
      for (int k = 0; k < LANES; k++) p1_prod[k] <= '0;
    end else begin
      p1_valid  <= in_fire;
      p2_valid  <= p1_valid;
      acc_valid <= p2_valid;
      if (in_fire) begin
        for (int k = 0; k < LANES; k++) p1_prod[k] <= prod_c[k];
        beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);
        if (beat_cnt == '0) begin
          bias_reg    <= bias;
          relu_en_reg <= relu_en;
        end
      end
      if (p1_valid) p2_sum <= lane_sum;
      if (out_fire)      acc <= '0;
      else if (p2_valid) acc <= acc + p2_sum;
      if (state == DRAIN && pipe_empty) begin
        z         <= (relu_en_reg && acc_bias[ACC_WIDTH-1]) ? '0 : acc_bias;
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_neuron_seq.sv
// tb/tb_fc_neuron_seq.sv - directed self-checking bench for fc_neuron_seq
module tb_fc_neuron_seq;

  localparam int WIDTH = 8, W_WIDTH = 8, IN = 128, LANES = 4, ACC_WIDTH = 24;
  localparam int BEATS = IN / LANES;

  logic                               clk = 1'b0;
  logic                               rst_n = 1'b0;
  logic                               relu_en = 1'b0;
  logic signed [WIDTH+W_WIDTH-1:0]    bias = '0;
  logic                               in_valid = 1'b0;
  logic                               in_ready;
  logic [LANES*WIDTH-1:0]             x_data = '0;
  logic [LANES*W_WIDTH-1:0]           w_data = '0;
  logic                               out_valid;
  logic                               out_ready = 1'b1;
  logic signed [ACC_WIDTH-1:0]        z;

  logic signed [WIDTH-1:0]   xv [IN];
  logic signed [W_WIDTH-1:0] wv [IN];
  int checks = 0;
  int failures = 0;

  fc_neuron_seq #(.WIDTH(WIDTH), .W_WIDTH(W_WIDTH), .IN(IN), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .relu_en(relu_en), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x_data(x_data), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  always #5 clk = ~clk;

  task automatic fill(input int x, input int w);
    for (int i = 0; i < IN; i++) begin
      xv[i] = WIDTH'(x);
      wv[i] = W_WIDTH'(w);
    end
  endtask

  // Sends nbeats beats; relu/bias take *_first on beat 0 and *_rest afterwards.
  task automatic send_neuron(input int nbeats, input logic rf, input logic rr,
                             input int bf, input int br, input bit bubbles);
    int guard;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      if (bubbles) begin
        while ($urandom_range(1, 0) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        x_data[k*WIDTH +: WIDTH]     = xv[b*LANES + k];
        w_data[k*W_WIDTH +: W_WIDTH] = wv[b*LANES + k];
      end
      relu_en = (b == 0) ? rf : rr;
      bias    = (b == 0) ? 16'(bf) : 16'(br);
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        checks++; failures++;
        $display("FAIL send_ready beat=%0d in_ready=%0b required=1", b, in_ready);
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit ir_seen);
    lat = 0;
    ir_seen = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) ir_seen = 1'b1;
    end while (!out_valid && lat < 200);
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL out_timeout out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic check_z(input string name, input int expv);
    logic signed [ACC_WIDTH-1:0] e;
    e = ACC_WIDTH'(expv);
    checks++;
    if (z !== e) begin
      failures++;
      $display("FAIL %s z=%0d required=%0d", name, z, e);
    end
  endtask

  task automatic finish_out(input string name);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_handshake out_valid=%0b in_ready=%0b required=0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== '0) begin
      failures++;
      $display("FAIL reset in_ready=%0b out_valid=%0b z=%0d required=1/0/0", in_ready, out_valid, z);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ones;
    int lat; bit irs;
    fill(1, 1);
    send_neuron(BEATS, 1'b1, 1'b1, 0, 0, 1'b0);
    wait_out(lat, irs);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL ones_latency edges=%0d required=4", lat);
    end
    check_z("ones", 128);
    finish_out("ones");
  endtask

  task automatic test_relu;
    int lat; bit irs;
    fill(1, -1);
    send_neuron(BEATS, 1'b1, 1'b1, 5, 5, 1'b0);
    wait_out(lat, irs);
    check_z("relu_on", 0);
    finish_out("relu_on");
    // relu_en/bias change after the first beat must not affect this neuron
    send_neuron(BEATS, 1'b0, 1'b1, 5, 100, 1'b0);
    wait_out(lat, irs);
    check_z("relu_off_sampled", -123);
    finish_out("relu_off");
  endtask

  task automatic test_extreme;
    int lat; bit irs;
    fill(-128, -128);
    send_neuron(BEATS, 1'b1, 1'b1, -32768, -32768, 1'b0);
    wait_out(lat, irs);
    check_z("extreme", 2064384);
    finish_out("extreme");
  endtask

  task automatic test_random_bubbles;
    int lat; bit irs; int gold; int bv;
    for (int r = 0; r < 2; r++) begin
      gold = 0;
      for (int i = 0; i < IN; i++) begin
        xv[i] = WIDTH'($urandom);
        wv[i] = W_WIDTH'($urandom);
        gold += int'(xv[i]) * int'(wv[i]);
      end
      bv = $urandom_range(65535, 0) - 32768;
      gold += bv;
      if (r == 1 && gold < 0) gold = 0;
      send_neuron(BEATS, r[0], r[0], bv, bv, 1'b1);
      wait_out(lat, irs);
      check_z("random", gold);
      checks++;
      if (irs !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL random_drain_ready seen=%0b now=%0b required=0", irs, in_ready);
      end
      finish_out("random");
    end
  endtask

  task automatic test_back_to_back_stall;
    int lat; bit irs; bit bad_z; bit bad_rdy;
    out_ready = 1'b0;
    fill(3, -2);
    send_neuron(BEATS, 1'b0, 1'b0, 10, 10, 1'b0);
    wait_out(lat, irs);
    bad_z = 1'b0;
    bad_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_data = $urandom;
      w_data = $urandom;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || z !== -24'sd758) bad_z = 1'b1;
      if (in_ready !== 1'b0) bad_rdy = 1'b1;
    end
    checks++;
    if (bad_z) begin
      failures++;
      $display("FAIL stall_hold out_valid=%0b z=%0d required=1/-758", out_valid, z);
    end
    checks++;
    if (bad_rdy) begin
      failures++;
      $display("FAIL stall_ready in_ready=%0b required=0", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_out("stall");
    fill(1, 2);
    send_neuron(BEATS, 1'b0, 1'b0, 0, 0, 1'b0);
    wait_out(lat, irs);
    check_z("after_stall", 256);
    finish_out("after_stall");
  endtask

  task automatic test_mid_reset;
    int lat; bit irs;
    fill(5, 5);
    send_neuron(17, 1'b0, 1'b0, 7, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (z !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset z=%0d out_valid=%0b in_ready=%0b required=0/0/1", z, out_valid, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill(2, 3);
    send_neuron(BEATS, 1'b1, 1'b1, 1, 1, 1'b0);
    wait_out(lat, irs);
    check_z("fresh_after_reset", 769);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL fresh_latency edges=%0d required=4", lat);
    end
    finish_out("fresh");
  endtask

  initial begin
    test_reset();
    test_ones();
    test_relu();
    test_extreme();
    test_random_bubbles();
    test_back_to_back_stall();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
